mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
Parametrised successor to the team's single-cycle MIPS behavioural model. A multi-cycle FSM core that executes a MIPS subset through external instruction and data memory ports with ready handshakes. It emits a one-cycle write-back trace for the bench's golden-model comparison, and adds bus-timeout halt plus new instructions (bne, slt, nop). Sits between the testbench memories and the trace checker.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
WAIT_LIMIT, 16, max cycles a req may stay unanswered before halt; 0 = wait forever
WAIT_W, 8, width of the wait counter; must hold WAIT_LIMIT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_ready  in  1  imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store
dmem_addr  out  32  byte address, bits [1:0] forced 0
dmem_wdata  out  32  store data
dmem_ready  in  1  access complete; dmem_rdata valid for loads
dmem_rdata  in  32  load data
wb_valid  out  1  one-cycle pulse on register write
wb_pc  out  32  pc of the writing instruction
wb_reg  out  5  destination register
wb_data  out  32  value written
illegal  out  1  one-cycle pulse on unsupported encoding
halted  out  1  sticky; set on bus timeout

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=FETCH, all 32 GPRs=0, every output 0, wait counter 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ready. On ready: latch instr, go to DECODE.
- DECODE: read rs/rt; go to EXEC.
- EXEC:
  - add/sub/slt (signed)/ori (zero-ext)/lui go to WB.
  - lw/sw compute rs+signext(imm), then go to MEM.
  - beq/bne/jr/jal resolve the next pc. jal goes to WB; the others go to FETCH.
  - sll encoding 0 (nop) goes to FETCH.
  - Any other encoding: illegal pulses 1 cycle, treated as nop.
- MEM: dmem_req=1 with addr/we/wdata held until dmem_ready. lw then goes to WB; sw goes to FETCH.
- WB: write GPR; wb_valid=1 for exactly this cycle with wb_pc/wb_reg/wb_data. Go to FETCH.
- Writes to $0: wb_valid still pulses with wb_reg=0, but $0 stays 0.
- Arithmetic: 32-bit wrap, no overflow trap.
- Branch target: pc+4+(signext(imm)<<2). jal target: {pc[31:28],instr[25:0],2'b00}. jr: rs, no alignment check.
- Next pc for non-control instructions: pc+4, updated on leaving EXEC/MEM/WB.
- Latency with zero-wait memories: ALU/jal 4 cycles, lw 5, sw 4, branch/nop 3.
- Timeout: a wait counter increments each cycle a req is high without ready and clears when ready arrives. If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT: req drops, state=HALT, halted=1. Only reset leaves HALT.
- Ready seen while req=0 is ignored.
- Reset mid-access drops req immediately; no GPR write occurs.

Optional Feature:
DELAY_SLOT_EN.
- Defined: the instruction at branch_pc+4 always executes after a taken branch/jump; the target is fetched after it. jal link = pc+8.
- Undefined: the target is fetched immediately after the control instruction. jal link = pc+4.
- Not-taken branches behave identically in both builds.

Test Plan:
- Zero-wait memories; ori $1,$0,0x1234 at 0x3000 -> wb_valid on cycle 4 after reset release; wb_pc=0x3000, wb_reg=1, wb_data=0x00001234.
- lui $2,0xffff; ori $2,$2,1; sw $2,8($0); lw $3,8($0) -> dmem store addr 0x8, wdata 0xffff0001; $3 trace = 0xffff0001.
- beq $0,$0,+2 at 0x3000, ori at 0x3004:
  - DELAY_SLOT_EN: fetches 0x3000, 0x3004, 0x300c.
  - Without: fetches 0x3000, 0x300c; no trace from 0x3004.
- jal at 0x3000 -> wb_reg=31, wb_data=0x3008 with DELAY_SLOT_EN, 0x3004 without. Then jr $31 returns to that pc.
- imem_ready held low, WAIT_LIMIT=16 -> halted=1 after 16 req cycles, imem_req=0. Subsequent imem_ready is ignored until reset.
- Random 0-5 wait states on both ports during the add/sub/slt/bne program -> trace identical to the zero-wait run.
- reset asserted mid-MEM -> outputs 0 asynchronously; no wb_valid; restart fetch at 0x3000.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// Instruction and data memory ports of mips_multicycle_core.
// The core is the master; memories answer with ready pulses.
interface mips_multicycle_core_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core with ready-handshake memories, write-back trace and bus timeout.
// Build macro DELAY_SLOT_EN: taken branches/jumps execute the next sequential instruction first.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int unsigned WAIT_LIMIT = 16,
   parameter int unsigned WAIT_W     = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   mips_multicycle_core_if.master io_bus,
   output logic                   o_wb_valid,
   output logic [31:0]            o_wb_pc,
   output logic [4:0]             o_wb_reg,
   output logic [31:0]            o_wb_data,
   output logic                   o_illegal,
   output logic                   o_halted
);
   localparam logic [2:0] StFetch  = 3'd0;
   localparam logic [2:0] StDecode = 3'd1;
   localparam logic [2:0] StExec   = 3'd2;
   localparam logic [2:0] StMem    = 3'd3;
   localparam logic [2:0] StWb     = 3'd4;
   localparam logic [2:0] StHalt   = 3'd5;

   localparam logic [WAIT_W-1:0] WaitLast = (WAIT_LIMIT == 0) ? '0 : WAIT_W'(WAIT_LIMIT - 1);

   logic [2:0]        r_state;
   logic [31:0]       r_pc;
   logic [31:0]       r_instr;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [31:0]       r_result;
   logic [31:0]       r_npc;
   logic [4:0]        r_dst;
   logic              r_is_st;
   logic [WAIT_W-1:0] r_wait;
   logic [31:0]       r_gpr [32];
`ifdef DELAY_SLOT_EN
   logic              r_br_pend;
   logic [31:0]       r_br_target;
`endif

   logic [2:0]  w_state_nxt;
   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [31:0] w_sext;
   logic [31:0] w_pc4;
   logic [31:0] w_link;
   logic [31:0] w_res;
   logic [4:0]  w_dst;
   logic [31:0] w_target;
   logic [31:0] w_npc;
   logic        w_taken;
   logic        w_is_wb;
   logic        w_is_mem;
   logic        w_is_st;
   logic        w_ill;
   logic        w_stall;
   logic        w_timeout;
   logic        w_fetch;
   logic        w_mem;
   logic        w_wb;

   assign w_op    = r_instr[31:26];
   assign w_funct = r_instr[5:0];
   assign w_rs    = r_instr[25:21];
   assign w_rt    = r_instr[20:16];
   assign w_rd    = r_instr[15:11];
   assign w_sext  = {{16{r_instr[15]}}, r_instr[15:0]};
   assign w_pc4   = r_pc + 32'd4;
`ifdef DELAY_SLOT_EN
   assign w_link  = r_pc + 32'd8;
   // A pending target belongs to the previous control instruction; this one is its slot.
   assign w_npc   = r_br_pend ? r_br_target : w_pc4;
`else
   assign w_link  = w_pc4;
   assign w_npc   = w_taken ? w_target : w_pc4;
`endif

   always_comb begin
      w_res    = '0;
      w_dst    = '0;
      w_target = '0;
      w_taken  = 1'b0;
      w_is_wb  = 1'b0;
      w_is_mem = 1'b0;
      w_is_st  = 1'b0;
      w_ill    = 1'b0;
      case (w_op)
         6'h00: begin
            case (w_funct)
               6'h20: begin w_res = r_a + r_b; w_dst = w_rd; w_is_wb = 1'b1; end
               6'h22: begin w_res = r_a - r_b; w_dst = w_rd; w_is_wb = 1'b1; end
               6'h2a: begin
                  w_res   = {31'h0, $signed(r_a) < $signed(r_b)};
                  w_dst   = w_rd;
                  w_is_wb = 1'b1;
               end
               6'h08: begin w_target = r_a; w_taken = 1'b1; end
               6'h00: w_ill = (r_instr != 32'h0);
               default: w_ill = 1'b1;
            endcase
         end
         6'h0d: begin w_res = r_a | {16'h0, r_instr[15:0]}; w_dst = w_rt; w_is_wb = 1'b1; end
         6'h0f: begin w_res = {r_instr[15:0], 16'h0}; w_dst = w_rt; w_is_wb = 1'b1; end
         6'h23: begin w_res = r_a + w_sext; w_dst = w_rt; w_is_mem = 1'b1; end
         6'h2b: begin w_res = r_a + w_sext; w_is_mem = 1'b1; w_is_st = 1'b1; end
         6'h04: begin w_target = w_pc4 + {w_sext[29:0], 2'b00}; w_taken = (r_a == r_b); end
         6'h05: begin w_target = w_pc4 + {w_sext[29:0], 2'b00}; w_taken = (r_a != r_b); end
         6'h03: begin
            w_target = {r_pc[31:28], r_instr[25:0], 2'b00};
            w_taken  = 1'b1;
            w_res    = w_link;
            w_dst    = 5'd31;
            w_is_wb  = 1'b1;
         end
         default: w_ill = 1'b1;
      endcase
   end

   assign w_stall   = (r_state == StFetch && !io_bus.imem_ready) ||
                      (r_state == StMem && !io_bus.dmem_ready);
   assign w_timeout = (WAIT_LIMIT != 0) && (r_wait == WaitLast);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StFetch: begin
            if (io_bus.imem_ready)  w_state_nxt = StDecode;
            else if (w_timeout)     w_state_nxt = StHalt;
         end
         StDecode: w_state_nxt = StExec;
         StExec: begin
            if (w_is_mem)      w_state_nxt = StMem;
            else if (w_is_wb)  w_state_nxt = StWb;
            else               w_state_nxt = StFetch;
         end
         StMem: begin
            if (io_bus.dmem_ready)  w_state_nxt = r_is_st ? StFetch : StWb;
            else if (w_timeout)     w_state_nxt = StHalt;
         end
         StWb:    w_state_nxt = StFetch;
         StHalt:  w_state_nxt = StHalt;
         default: w_state_nxt = StFetch;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StFetch;
         r_pc     <= RESET_PC;
         r_instr  <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_npc    <= '0;
         r_dst    <= '0;
         r_is_st  <= 1'b0;
         r_wait   <= '0;
         for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
`ifdef DELAY_SLOT_EN
         r_br_pend   <= 1'b0;
         r_br_target <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_stall ? r_wait + 1'b1 : '0;
         case (r_state)
            StFetch: if (io_bus.imem_ready) r_instr <= io_bus.imem_rdata;
            StDecode: begin
               r_a <= r_gpr[w_rs];
               r_b <= r_gpr[w_rt];
            end
            StExec: begin
               r_result <= w_res;
               r_dst    <= w_dst;
               r_is_st  <= w_is_st;
               r_npc    <= w_npc;
               if (w_state_nxt == StFetch) r_pc <= w_npc;
`ifdef DELAY_SLOT_EN
               r_br_pend <= w_taken;
               if (w_taken) r_br_target <= w_target;
`endif
            end
            StMem: begin
               if (io_bus.dmem_ready) begin
                  if (r_is_st) r_pc <= r_npc;
                  else         r_result <= io_bus.dmem_rdata;
               end
            end
            StWb: begin
               if (r_dst != 5'd0) r_gpr[r_dst] <= r_result;
               r_pc <= r_npc;
            end
            default: ;
         endcase
      end
   end

   // The FSM rests in FETCH during reset, so the fetch request is gated by reset directly.
   assign w_fetch = i_rst_n && (r_state == StFetch);
   assign w_mem   = (r_state == StMem);
   assign w_wb    = (r_state == StWb);

   assign io_bus.imem_req   = w_fetch;
   assign io_bus.imem_addr  = w_fetch ? r_pc : '0;
   assign io_bus.dmem_req   = w_mem;
   assign io_bus.dmem_we    = w_mem && r_is_st;
   assign io_bus.dmem_addr  = w_mem ? {r_result[31:2], 2'b00} : '0;
   assign io_bus.dmem_wdata = w_mem ? r_b : '0;

   assign o_wb_valid = w_wb;
   assign o_wb_pc    = w_wb ? r_pc : '0;
   assign o_wb_reg   = w_wb ? r_dst : '0;
   assign o_wb_data  = w_wb ? r_result : '0;
   assign o_illegal  = (r_state == StExec) && w_ill;
   assign o_halted   = (r_state == StHalt);
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: memory models with programmable wait states,
// trace/fetch monitors and hand-computed expectations (both DELAY_SLOT_EN builds).
module tb_mips_multicycle_core;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        illegal;
   logic        halted;

   mips_multicycle_core_if bus ();

   mips_multicycle_core dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .io_bus     (bus),
      .o_wb_valid (wb_valid),
      .o_wb_pc    (wb_pc),
      .o_wb_reg   (wb_reg),
      .o_wb_data  (wb_data),
      .o_illegal  (illegal),
      .o_halted   (halted)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   logic        imem_block, imem_force, rand_waits;
   int unsigned fixed_dlat;
   int unsigned icnt, ilat, dcnt, dlat;
   logic [31:0] ioff;
   logic [31:0] last_st_addr, last_st_data;

   assign ioff = bus.imem_addr - 32'h3000;
   assign bus.imem_ready = (bus.imem_req && icnt >= ilat && !imem_block) || imem_force;
   assign bus.imem_rdata = (bus.imem_ready && ioff < 32'd256) ? imem[ioff[7:2]] : 32'h0;
   assign bus.dmem_ready = bus.dmem_req && dcnt >= dlat;
   assign bus.dmem_rdata = bus.dmem_ready ? dmem[bus.dmem_addr[7:2]] : 32'h0;

   always @(posedge clk) begin
      if (bus.imem_req && !bus.imem_ready) icnt <= icnt + 1;
      else begin
         icnt <= 0;
         ilat <= rand_waits ? $urandom_range(0, 5) : 0;
      end
      if (bus.dmem_req && !bus.dmem_ready) dcnt <= dcnt + 1;
      else begin
         dcnt <= 0;
         dlat <= rand_waits ? $urandom_range(0, 5) : fixed_dlat;
      end
      if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
         dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
         last_st_addr <= bus.dmem_addr;
         last_st_data <= bus.dmem_wdata;
      end
   end

   logic [31:0] t_pc[$], t_data[$], f_addr[$];
   logic [4:0]  t_reg[$];
   int          ill_cnt;
   logic [31:0] e_pc[$], e_data[$];
   logic [4:0]  e_reg[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (wb_valid) begin
            t_pc.push_back(wb_pc);
            t_reg.push_back(wb_reg);
            t_data.push_back(wb_data);
         end
         if (bus.imem_req && bus.imem_ready) f_addr.push_back(bus.imem_addr);
         if (illegal) ill_cnt++;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
      rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
      itype = {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic enter_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      t_pc.delete(); t_reg.delete(); t_data.delete(); f_addr.delete();
      ill_cnt = 0;
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
   endtask

   task automatic leave_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic add_exp(input logic [31:0] pc, input int rg, input logic [31:0] d);
      e_pc.push_back(pc);
      e_reg.push_back(5'(rg));
      e_data.push_back(d);
   endtask

   task automatic compare_trace(input string tag);
      check({tag, "_len"}, 32'(t_pc.size()), 32'(e_pc.size()));
      for (int i = 0; i < e_pc.size(); i++) begin
         check($sformatf("%s_pc%0d", tag, i), t_pc[i], e_pc[i]);
         check($sformatf("%s_reg%0d", tag, i), 32'(t_reg[i]), 32'(e_reg[i]));
         check($sformatf("%s_data%0d", tag, i), t_data[i], e_data[i]);
      end
   endtask

   initial begin
      rst_n = 1'b0; imem_block = 1'b0; imem_force = 1'b0; rand_waits = 1'b0; fixed_dlat = 0;

      // Single ori: reset values and 4-cycle ALU latency
      enter_reset();
      imem[0] = itype(6'h0d, 0, 1, 16'h1234);
      check("rst_imem_req", 32'(bus.imem_req), 0);
      check("rst_imem_addr", bus.imem_addr, 0);
      check("rst_dmem_req", 32'(bus.dmem_req), 0);
      check("rst_wb_valid", 32'(wb_valid), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_illegal", 32'(illegal), 0);
      leave_reset();
      check("c1_imem_req", 32'(bus.imem_req), 1);
      check("c1_imem_addr", bus.imem_addr, 32'h3000);
      tick(2);
      check("c3_wb_valid", 32'(wb_valid), 0);
      tick(1);
      check("c4_wb_valid", 32'(wb_valid), 1);
      check("c4_wb_pc", wb_pc, 32'h3000);
      check("c4_wb_reg", 32'(wb_reg), 1);
      check("c4_wb_data", wb_data, 32'h0000_1234);
      tick(1);
      check("c5_wb_valid", 32'(wb_valid), 0);

      // lui/ori/sw/lw
      enter_reset();
      imem[0] = itype(6'h0f, 0, 2, 16'hffff);
      imem[1] = itype(6'h0d, 2, 2, 16'h0001);
      imem[2] = itype(6'h2b, 0, 2, 16'h0008);
      imem[3] = itype(6'h23, 0, 3, 16'h0008);
      leave_reset();
      tick(30);
      check("st_addr", last_st_addr, 32'h8);
      check("st_data", last_st_data, 32'hffff_0001);
      check("ld_len", 32'(t_pc.size()), 3);
      check("ld_pc", t_pc[2], 32'h300c);
      check("ld_reg", 32'(t_reg[2]), 3);
      check("ld_data", t_data[2], 32'hffff_0001);

      // Taken beq
      enter_reset();
      imem[0] = itype(6'h04, 0, 0, 16'h0002);
      imem[1] = itype(6'h0d, 0, 4, 16'h0005);
      imem[2] = itype(6'h0d, 0, 5, 16'h0007);
      imem[3] = itype(6'h0d, 0, 6, 16'h0009);
      leave_reset();
      tick(20);
      check("beq_f0", f_addr[0], 32'h3000);
`ifdef DELAY_SLOT_EN
      check("beq_f1", f_addr[1], 32'h3004);
      check("beq_f2", f_addr[2], 32'h300c);
      check("beq_t0_pc", t_pc[0], 32'h3004);
      check("beq_t1_pc", t_pc[1], 32'h300c);
`else
      check("beq_f1", f_addr[1], 32'h300c);
      check("beq_f2", f_addr[2], 32'h3010);
      check("beq_t0_pc", t_pc[0], 32'h300c);
      check("beq_t0_reg", 32'(t_reg[0]), 6);
`endif

      // jal / jr round trip
      enter_reset();
      imem[0] = {6'h03, 26'h000_0c04};
      imem[1] = itype(6'h0d, 0, 7, 16'h0001);
      imem[2] = itype(6'h0d, 0, 8, 16'h0002);
      imem[4] = rtype(31, 0, 0, 6'h08);
      leave_reset();
      tick(40);
      check("jal_pc", t_pc[0], 32'h3000);
      check("jal_reg", 32'(t_reg[0]), 31);
`ifdef DELAY_SLOT_EN
      check("jal_link", t_data[0], 32'h3008);
      check("jr_fetch", f_addr[4], 32'h3008);
`else
      check("jal_link", t_data[0], 32'h3004);
      check("jr_fetch", f_addr[2], 32'h3004);
`endif
      check("jr_t1_pc", t_pc[1], 32'h3004);
      check("jr_t2_pc", t_pc[2], 32'h3008);
      check("jr_t2_data", t_data[2], 32'h2);

      // Fetch timeout
      enter_reset();
      imem_block = 1'b1;
      leave_reset();
      tick(15);
      check("to_req_c16", 32'(bus.imem_req), 1);
      check("to_halted_c16", 32'(halted), 0);
      tick(1);
      check("to_halted", 32'(halted), 1);
      check("to_req", 32'(bus.imem_req), 0);
      imem_block = 1'b0;
      imem_force = 1'b1;
      tick(5);
      check("to_sticky", 32'(halted), 1);
      check("to_req_idle", 32'(bus.imem_req), 0);
      check("to_no_fetch", 32'(f_addr.size()), 0);
      imem_force = 1'b0;

      // ALU/branch/memory program, zero-wait then random waits
      add_exp(32'h3000, 1, 32'd5);
      add_exp(32'h3004, 2, 32'd3);
      add_exp(32'h3008, 3, 32'd8);
      add_exp(32'h300c, 4, 32'hffff_fffe);
      add_exp(32'h3010, 5, 32'd1);
      add_exp(32'h3014, 6, 32'd0);
`ifdef DELAY_SLOT_EN
      add_exp(32'h301c, 7, 32'h0bad);
`endif
      add_exp(32'h3020, 8, 32'd9);
      add_exp(32'h3028, 9, 32'd9);
      add_exp(32'h302c, 0, 32'd10);
      add_exp(32'h3030, 10, 32'd0);
      for (int pass = 0; pass < 2; pass++) begin
         enter_reset();
         imem[0]  = itype(6'h0d, 0, 1, 16'd5);
         imem[1]  = itype(6'h0d, 0, 2, 16'd3);
         imem[2]  = rtype(1, 2, 3, 6'h20);
         imem[3]  = rtype(2, 1, 4, 6'h22);
         imem[4]  = rtype(4, 1, 5, 6'h2a);
         imem[5]  = rtype(1, 4, 6, 6'h2a);
         imem[6]  = itype(6'h05, 5, 6, 16'd1);
         imem[7]  = itype(6'h0d, 0, 7, 16'h0bad);
         imem[8]  = rtype(3, 5, 8, 6'h20);
         imem[9]  = itype(6'h2b, 0, 8, 16'd16);
         imem[10] = itype(6'h23, 0, 9, 16'd16);
         imem[11] = rtype(1, 1, 0, 6'h20);
         imem[12] = rtype(0, 0, 10, 6'h20);
         imem[13] = 32'hfc00_0000;
         rand_waits = (pass == 1);
         leave_reset();
         tick(pass == 0 ? 150 : 600);
         compare_trace(pass == 0 ? "zw" : "rw");
         check(pass == 0 ? "zw_illegal" : "rw_illegal", 32'(ill_cnt), 1);
      end
      rand_waits = 1'b0;

      // Reset in the middle of a load
      enter_reset();
      imem[0] = itype(6'h23, 0, 3, 16'h0008);
      fixed_dlat = 3;
      tick(1);
      leave_reset();
      for (int i = 0; i < 20 && !bus.dmem_req; i++) tick(1);
      check("mr_in_mem", 32'(bus.dmem_req), 1);
      tick(1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_dmem_req", 32'(bus.dmem_req), 0);
      check("mr_dmem_addr", bus.dmem_addr, 0);
      check("mr_imem_req", 32'(bus.imem_req), 0);
      check("mr_wb_valid", 32'(wb_valid), 0);
      tick(3);
      check("mr_no_wb", 32'(t_pc.size()), 0);
      leave_reset();
      check("mr_restart_req", 32'(bus.imem_req), 1);
      check("mr_restart_addr", bus.imem_addr, 32'h3000);
      fixed_dlat = 0;
      tick(5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
